gray_switch_decoder: RTL and testbench

GRAY_SWITCH_DECODER -- requirements
Module: gray_switch_decoder

---
 rtl/gray_switch_decoder.sv | 141 ++++++++++++++
 tb/tb_gray_switch_decoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_switch_decoder.sv
// Debounced Gray-code switch decoder.
// Raw switch code is synchronized, held for DEBOUNCE_CYCLES identical
// samples, then converted to binary and presented with a one-cycle strobe.
//
// state    | meaning
// ---------+------------------------------------------------------------
// STABLE   | sync2 matches the last accepted code; counter idle at 0
// COUNTING | a different candidate code is being qualified
module gray_switch_decoder #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] grayIn,
    output logic [3:0] binNumber,
    output logic       binValid,
    output logic       busy,
    output logic [7:0] bounceCount
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       BOUNCE_MAX = 8'd255;

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       stable_gray_q, stable_gray_d;
    logic [3:0]       candidate_q, candidate_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [3:0]       bin_number_q, bin_number_d;
    logic             bin_valid_q, bin_valid_d;
    logic             busy_q, busy_d;
    logic [7:0]       bounce_count_q, bounce_count_d;

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    // Two-flop synchronizer for the asynchronous switch inputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
        end else begin
            sync1_q <= grayIn;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= STABLE;
            stable_gray_q  <= 4'b0000;
            candidate_q    <= 4'b0000;
            counter_q      <= '0;
            bin_number_q   <= 4'b0000;
            bin_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            bounce_count_q <= 8'd0;
        end else begin
            state_q        <= state_d;
            stable_gray_q  <= stable_gray_d;
            candidate_q    <= candidate_d;
            counter_q      <= counter_d;
            bin_number_q   <= bin_number_d;
            bin_valid_q    <= bin_valid_d;
            busy_q         <= busy_d;
            bounce_count_q <= bounce_count_d;
        end
    end

    // Next-state decode: qualify, restart, abort or accept the candidate.
    always_comb begin
        state_d        = state_q;
        stable_gray_d  = stable_gray_q;
        candidate_d    = candidate_q;
        counter_d      = counter_q;
        bin_number_d   = bin_number_q;
        bin_valid_d    = 1'b0;
        bounce_count_d = bounce_count_q;

        case (state_q)
            STABLE: begin
                if (sync2_q != stable_gray_q) begin
                    state_d     = COUNTING;
                    candidate_d = sync2_q;
                    counter_d   = CNT_ONE;
                end else begin
                    counter_d = '0;
                end
            end
            COUNTING: begin
                if (sync2_q == stable_gray_q) begin
                    // Input fell back to the accepted code: abandon candidate.
                    state_d   = STABLE;
                    counter_d = '0;
                    if (bounce_count_q != BOUNCE_MAX)
                        bounce_count_d = bounce_count_q + 8'd1;
                end else if (sync2_q != candidate_q) begin
                    // A third code appeared: restart qualification on it.
                    candidate_d = sync2_q;
                    counter_d   = CNT_ONE;
                    if (bounce_count_q != BOUNCE_MAX)
                        bounce_count_d = bounce_count_q + 8'd1;
                end else if (counter_q == CNT_LAST) begin
                    state_d       = STABLE;
                    stable_gray_d = candidate_q;
                    bin_number_d  = gray2bin(candidate_q);
                    bin_valid_d   = 1'b1;
                    counter_d     = '0;
                end else begin
                    counter_d = counter_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = STABLE;
                counter_d = '0;
            end
        endcase

        busy_d = (state_d == COUNTING);
    end

    assign binNumber   = bin_number_q;
    assign binValid    = bin_valid_q;
    assign busy        = busy_q;
    assign bounceCount = bounce_count_q;

endmodule

// File: tb/tb_gray_switch_decoder.sv
// Bench for gray_switch_decoder with a short debounce window.
module tb_gray_switch_decoder;

    localparam int D = 4;

    logic       clock;
    logic       reset;
    logic [3:0] grayIn;
    logic [3:0] binNumber;
    logic       binValid;
    logic       busy;
    logic [7:0] bounceCount;

    gray_switch_decoder #(.DEBOUNCE_CYCLES(D)) dut (
        .clock      (clock),
        .reset      (reset),
        .grayIn     (grayIn),
        .binNumber  (binNumber),
        .binValid   (binValid),
        .busy       (busy),
        .bounceCount(bounceCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: pipeline of raw samples plus a run-length qualifier.
    logic [3:0] m_pipe [2];
    logic [3:0] m_stable, m_cand, m_bin;
    int         m_run;
    int         m_bounce;
    bit         m_valid;
    bit         prev_valid;
    int         pulses;
    int         busy_cycles;

    typedef struct {
        logic [3:0] gray;
        logic [3:0] exp_bin;
        int         exp_pulses;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [3:0] ref_bin(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    task automatic model_reset();
        m_pipe[0] = 4'd0;
        m_pipe[1] = 4'd0;
        m_stable  = 4'd0;
        m_cand    = 4'd0;
        m_bin     = 4'd0;
        m_run     = 0;
        m_bounce  = 0;
        m_valid   = 1'b0;
        prev_valid = 1'b0;
    endtask

    task automatic bump();
        if (m_bounce < 255) m_bounce++;
    endtask

    task automatic model_step(input logic [3:0] g);
        logic [3:0] s;
        s = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = g;
        m_valid = 1'b0;
        if (m_run == 0) begin
            if (s != m_stable) begin
                m_cand = s;
                m_run  = 1;
            end
        end else if (s == m_stable) begin
            m_run = 0;
            bump();
        end else if (s != m_cand) begin
            m_cand = s;
            m_run  = 1;
            bump();
        end else begin
            m_run++;
            if (m_run == D) begin
                m_stable = m_cand;
                m_bin    = ref_bin(m_cand);
                m_valid  = 1'b1;
                m_run    = 0;
            end
        end
    endtask

    // One clock with grayIn held at g; outputs compared 1 time unit after the edge.
    task automatic tick(input logic [3:0] g);
        grayIn = g;
        @(posedge clock);
        if (reset) model_reset();
        else       model_step(g);
        #1;
        check("binNumber", binNumber, m_bin);
        check("binValid", binValid, m_valid);
        check("busy", busy, (m_run != 0) ? 1 : 0);
        check("bounceCount", bounceCount, m_bounce);
        check("valid_twice", (prev_valid && binValid) ? 1 : 0, 0);
        prev_valid = binValid;
        if (binValid) pulses++;
        if (busy) busy_cycles++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bin"}, binNumber, 0);
        check({tag, "_valid"}, binValid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_bounce"}, bounceCount, 0);
    endtask

    initial begin
        int b0;
        vecs[0]  = '{4'b0000, 4'b0000, 0};
        vecs[1]  = '{4'b0001, 4'b0001, 1};
        vecs[2]  = '{4'b0011, 4'b0010, 1};
        vecs[3]  = '{4'b0010, 4'b0011, 1};
        vecs[4]  = '{4'b0110, 4'b0100, 1};
        vecs[5]  = '{4'b0111, 4'b0101, 1};
        vecs[6]  = '{4'b0101, 4'b0110, 1};
        vecs[7]  = '{4'b0100, 4'b0111, 1};
        vecs[8]  = '{4'b1100, 4'b1000, 1};
        vecs[9]  = '{4'b1101, 4'b1001, 1};
        vecs[10] = '{4'b1111, 4'b1010, 1};
        vecs[11] = '{4'b1110, 4'b1011, 1};
        vecs[12] = '{4'b1010, 4'b1100, 1};
        vecs[13] = '{4'b1011, 4'b1101, 1};
        vecs[14] = '{4'b1001, 4'b1110, 1};
        vecs[15] = '{4'b1000, 4'b1111, 1};

        // Reset held with switches at 1111: everything stays zero.
        reset  = 1'b1;
        grayIn = 4'b1111;
        model_reset();
        pulses = 0;
        #2;
        check_all_zero("reset_async");
        for (int i = 0; i < 4; i++) begin
            tick(4'b1111);
            check_all_zero("in_reset");
        end
        check("reset_pulses", pulses, 0);

        // Release with 1111 held: one accept after the synchronizer plus D samples.
        reset = 1'b0;
        pulses = 0;
        busy_cycles = 0;
        for (int i = 0; i < D + 5; i++) tick(4'b1111);
        check("first_bin", binNumber, 4'b1010);
        check("first_pulses", pulses, 1);
        check("first_busy_cycles", busy_cycles, D - 1);
        check("first_bounce", bounceCount, 0);

        // Toggle 0111/0011 every cycle, then settle on 0111.
        b0 = bounceCount;
        pulses = 0;
        for (int i = 0; i < 6; i++) tick((i % 2 == 0) ? 4'b0111 : 4'b0011);
        for (int i = 0; i < D + 6; i++) tick(4'b0111);
        check("toggle_bin", binNumber, 4'b0101);
        check("toggle_pulses", pulses, 1);
        check("toggle_bounces", bounceCount - b0, 6);

        // Short glitch to 0001 then back: aborted attempt.
        b0 = bounceCount;
        pulses = 0;
        tick(4'b0001);
        tick(4'b0001);
        for (int i = 0; i < D + 4; i++) tick(4'b0111);
        check("abort_bin", binNumber, 4'b0101);
        check("abort_pulses", pulses, 0);
        check("abort_bounces", bounceCount - b0, 1);

        // Reset while qualifying 1000.
        for (int i = 0; i < 3; i++) tick(4'b1000);
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        #1;
        check_all_zero("midcount_reset");
        model_reset();
        tick(4'b1000);
        check_all_zero("midcount_held");
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < D + 5; i++) tick(4'b1000);
        check("after_reset_bin", binNumber, 4'b1111);
        check("after_reset_pulses", pulses, 1);

        // Saturate the bounce counter with continual restarts.
        for (int i = 0; i < 300; i++) tick((i % 2 == 0) ? 4'b0001 : 4'b0010);
        check("bounce_sat", bounceCount, 255);
        tick(4'b1000);
        tick(4'b1000);
        tick(4'b1000);
        check("bounce_sat_hold", bounceCount, 255);

        // Table sweep: every code after a fresh reset.
        reset = 1'b1;
        tick(4'b0000);
        reset = 1'b0;
        for (int v = 0; v < 16; v++) begin
            pulses = 0;
            for (int i = 0; i < D + 4; i++) tick(vecs[v].gray);
            check($sformatf("table_bin_%0d", v), binNumber, vecs[v].exp_bin);
            check($sformatf("table_pulses_%0d", v), pulses, vecs[v].exp_pulses);
        end

        // Random hold lengths around the debounce window, model-checked.
        for (int seg = 0; seg < 200; seg++) begin
            logic [3:0] g;
            int len;
            g   = 4'($urandom_range(0, 15));
            len = $urandom_range(1, D + 4);
            for (int i = 0; i < len; i++) tick(g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
